// File: rtl/button_press_detector.sv
// Turns the raw active-low push-button pin into a debounced level plus
// single-cycle press, release, short-press and long-press events.
module button_press_detector #(
   parameter logic [23:0] DEBOUNCE_CYCLES = 24'd120000,
   parameter logic [23:0] LONG_CYCLES     = 24'd12000000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       btn_n,
   output logic       btn_level,
   output logic       press_pulse,
   output logic       release_pulse,
   output logic       short_press,
   output logic       long_press,
   output logic [7:0] press_count
);

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      DB_PRESS   = 2'd1,
      PRESSED    = 2'd2,
      DB_RELEASE = 2'd3
   } state_t;

   localparam logic [23:0] DB_LAST   = DEBOUNCE_CYCLES - 24'd1;
   localparam logic [23:0] LONG_LAST = LONG_CYCLES - 24'd1;

   state_t      state;
   logic        s1;
   logic        s2;
   logic        btn_sync;
   logic [23:0] db_cnt;
   logic [23:0] hold_cnt;
   logic        long_flag;

   // Flops reset to 1 so the released (high) pin level is assumed at start-up.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1 <= 1'b1;
         s2 <= 1'b1;
      end else begin
         s1 <= btn_n;
         s2 <= s1;
      end
   end

   assign btn_sync = ~s2;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         db_cnt        <= 24'd0;
         hold_cnt      <= 24'd0;
         long_flag     <= 1'b0;
         btn_level     <= 1'b0;
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
         short_press   <= 1'b0;
         long_press    <= 1'b0;
         press_count   <= 8'd0;
      end else begin
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
         short_press   <= 1'b0;
         long_press    <= 1'b0;
         case (state)
            IDLE: begin
               db_cnt <= 24'd0;
               if (btn_sync) begin
                  state <= DB_PRESS;
               end
            end
            DB_PRESS: begin
               if (!btn_sync) begin
                  state  <= IDLE;
                  db_cnt <= 24'd0;
               end else if (db_cnt == DB_LAST) begin
                  state       <= PRESSED;
                  press_pulse <= 1'b1;
                  btn_level   <= 1'b1;
                  press_count <= press_count + 8'd1;
                  hold_cnt    <= 24'd0;
                  long_flag   <= 1'b0;
                  db_cnt      <= 24'd0;
               end else begin
                  db_cnt <= db_cnt + 24'd1;
               end
            end
            PRESSED: begin
               // A release edge wins over a long-press threshold hit in the same cycle.
               if (!btn_sync) begin
                  state  <= DB_RELEASE;
                  db_cnt <= 24'd0;
               end else if (!long_flag && (hold_cnt == LONG_LAST)) begin
                  long_press <= 1'b1;
                  long_flag  <= 1'b1;
               end else if (hold_cnt < LONG_LAST) begin
                  hold_cnt <= hold_cnt + 24'd1;
               end
            end
            DB_RELEASE: begin
               // hold_cnt stays frozen here so a rejected release bounce resumes the hold timer.
               if (btn_sync) begin
                  state <= PRESSED;
               end else if (db_cnt == DB_LAST) begin
                  state         <= IDLE;
                  release_pulse <= 1'b1;
                  btn_level     <= 1'b0;
                  short_press   <= ~long_flag;
                  db_cnt        <= 24'd0;
               end else begin
                  db_cnt <= db_cnt + 24'd1;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_button_press_detector.sv
// Bench for button_press_detector with short debounce/long thresholds and a
// run-length reference model of the debounced button behaviour.
module tb_button_press_detector;

   localparam int DEB  = 4;
   localparam int LONG = 20;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       btn_n = 1'b1;
   logic       btn_level;
   logic       press_pulse;
   logic       release_pulse;
   logic       short_press;
   logic       long_press;
   logic [7:0] press_count;

   int checks = 0;
   int errors = 0;

   button_press_detector #(
      .DEBOUNCE_CYCLES(24'd4),
      .LONG_CYCLES    (24'd20)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .btn_n        (btn_n),
      .btn_level    (btn_level),
      .press_pulse  (press_pulse),
      .release_pulse(release_pulse),
      .short_press  (short_press),
      .long_press   (long_press),
      .press_count  (press_count)
   );

   always #5 clk = ~clk;

   // Reference model: the pin reaches the logic two samples late; the level
   // flips after DEB+1 consecutive samples disagreeing with it; a long press
   // fires on the LONG-th sample that is pressed and preceded by a pressed sample.
   bit         sync_q[$];
   bit         m_raw;
   logic       m_sync;
   logic       m_prev;
   int         m_run;
   int         m_held;
   logic       m_long_done;
   logic       exp_level, exp_press, exp_release, exp_short, exp_long;
   logic [7:0] exp_count;

   wire [12:0] obs_vec = {btn_level, press_pulse, release_pulse, short_press, long_press, press_count};
   wire [12:0] exp_vec = {exp_level, exp_press, exp_release, exp_short, exp_long, exp_count};

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q = '{1'b1, 1'b1};
         m_prev = 1'b0;
         m_run = 0;
         m_held = 0;
         m_long_done = 1'b0;
         exp_level = 1'b0;
         exp_press = 1'b0;
         exp_release = 1'b0;
         exp_short = 1'b0;
         exp_long = 1'b0;
         exp_count = 8'd0;
      end else begin
         m_raw = sync_q.pop_front();
         sync_q.push_back(btn_n);
         m_sync = ~m_raw;
         exp_press = 1'b0;
         exp_release = 1'b0;
         exp_short = 1'b0;
         exp_long = 1'b0;
         if (exp_level && m_sync && m_prev) begin
            m_held++;
            if (m_held == LONG && !m_long_done) begin
               exp_long = 1'b1;
               m_long_done = 1'b1;
            end
         end
         if (m_sync != exp_level) m_run++;
         else m_run = 0;
         if (m_run == DEB + 1) begin
            m_run = 0;
            exp_level = m_sync;
            if (m_sync) begin
               exp_press = 1'b1;
               exp_count = exp_count + 8'd1;
               m_held = 0;
               m_long_done = 1'b0;
            end else begin
               exp_release = 1'b1;
               exp_short = !m_long_done;
            end
         end
         m_prev = m_sync;
      end
   end

   task automatic test_reset();
      int lat = -1;
      btn_n = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (obs_vec !== 13'd0) begin
         errors++;
         $display("FAIL reset_async: got %h expected %h", obs_vec, 13'd0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         checks++;
         if (obs_vec !== exp_vec) begin
            errors++;
            $display("FAIL reset_model cyc %0d: got %h expected %h", i, obs_vec, exp_vec);
         end
         if (press_pulse && lat < 0) lat = i;
      end
      checks++;
      if (lat !== DEB + 2) begin
         errors++;
         $display("FAIL reset_press_latency: got %0d expected %0d", lat, DEB + 2);
      end
      checks++;
      if (press_count !== 8'd1) begin
         errors++;
         $display("FAIL reset_press_count: got %0d expected 1", press_count);
      end
   endtask

   task automatic test_bounce();
      int pulses = 0;
      int level_hi = 0;
      bit stim[$] = '{1,1,1,1,1, 0, 1,1,1,1,1, 0,0, 1,1,1,1,1, 0,0,0, 1,1,1,1,1,1,1,1,1,1};
      btn_n = 1'b1;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      foreach (stim[i]) begin
         btn_n = stim[i];
         @(negedge clk);
         checks++;
         if (obs_vec !== exp_vec) begin
            errors++;
            $display("FAIL bounce_model cyc %0d: got %h expected %h", i, obs_vec, exp_vec);
         end
         pulses += int'(press_pulse) + int'(release_pulse) + int'(short_press) + int'(long_press);
         level_hi += int'(btn_level);
      end
      checks++;
      if (pulses != 0 || level_hi != 0) begin
         errors++;
         $display("FAIL bounce_quiet: got pulses=%0d level_cycles=%0d expected 0 0", pulses, level_hi);
      end
      checks++;
      if (press_count !== 8'd0) begin
         errors++;
         $display("FAIL bounce_count: got %0d expected 0", press_count);
      end
   endtask

   task automatic test_short();
      int press_i = -1, rel_i = -1, short_i = -1, longs = 0;
      for (int i = 0; i < 30; i++) begin
         btn_n = (i < 10) ? 1'b0 : 1'b1;
         @(negedge clk);
         checks++;
         if (obs_vec !== exp_vec) begin
            errors++;
            $display("FAIL short_model cyc %0d: got %h expected %h", i, obs_vec, exp_vec);
         end
         if (press_pulse) press_i = i;
         if (release_pulse) rel_i = i;
         if (short_press) short_i = i;
         longs += int'(long_press);
      end
      checks++;
      if (press_i != DEB + 2) begin
         errors++;
         $display("FAIL short_press_edge: got %0d expected %0d", press_i, DEB + 2);
      end
      checks++;
      if (rel_i != 10 + DEB + 2 || short_i != rel_i) begin
         errors++;
         $display("FAIL short_release_edge: got rel=%0d short=%0d expected %0d", rel_i, short_i, 10 + DEB + 2);
      end
      checks++;
      if (longs != 0) begin
         errors++;
         $display("FAIL short_no_long: got %0d expected 0", longs);
      end
   endtask

   task automatic hold_test(input int low1, input int gap, input int low2, input int exp_delay);
      int press_i = -1, long_i = -1, longs = 0, rels = 0, rel_short = -1, rel_i = -1;
      int total = low1 + gap + low2;
      for (int i = 0; i < total + 15; i++) begin
         btn_n = (i < low1 || (i >= low1 + gap && i < total)) ? 1'b0 : 1'b1;
         @(negedge clk);
         checks++;
         if (obs_vec !== exp_vec) begin
            errors++;
            $display("FAIL hold_model gap=%0d cyc %0d: got %h expected %h", gap, i, obs_vec, exp_vec);
         end
         if (press_pulse) press_i = i;
         if (long_press) begin
            long_i = i;
            longs++;
         end
         if (release_pulse) begin
            rels++;
            rel_i = i;
            rel_short = short_press;
         end
      end
      checks++;
      if (longs != 1 || long_i - press_i != exp_delay) begin
         errors++;
         $display("FAIL hold_long gap=%0d: got count=%0d delay=%0d expected 1 %0d", gap, longs, long_i - press_i, exp_delay);
      end
      checks++;
      if (rels != 1 || rel_i != total + DEB + 2 || rel_short != 0) begin
         errors++;
         $display("FAIL hold_release gap=%0d: got rels=%0d at %0d short=%0d expected 1 at %0d short=0", gap, rels, rel_i, rel_short, total + DEB + 2);
      end
   endtask

   task automatic test_long();
      hold_test(40, 0, 0, LONG);
   endtask

   task automatic test_release_bounce();
      // Two frozen samples plus the first pressed sample after the gap, which has no pressed predecessor.
      hold_test(10, 2, 30, LONG + 3);
   endtask

   task automatic test_mid_reset();
      int lat = -1;
      for (int i = 0; i < 12; i++) begin
         btn_n = 1'b0;
         @(negedge clk);
      end
      checks++;
      if (btn_level !== 1'b1) begin
         errors++;
         $display("FAIL midreset_pressed: got %b expected 1", btn_level);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (obs_vec !== 13'd0) begin
         errors++;
         $display("FAIL midreset_async: got %h expected %h", obs_vec, 13'd0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 30; i++) begin
         btn_n = (i < 15) ? 1'b0 : 1'b1;
         @(negedge clk);
         checks++;
         if (obs_vec !== exp_vec) begin
            errors++;
            $display("FAIL midreset_model cyc %0d: got %h expected %h", i, obs_vec, exp_vec);
         end
         if (press_pulse && lat < 0) lat = i;
      end
      checks++;
      if (lat != DEB + 2 || press_count !== 8'd1) begin
         errors++;
         $display("FAIL midreset_redetect: got lat=%0d count=%0d expected %0d 1", lat, press_count, DEB + 2);
      end
   endtask

   task automatic test_random();
      int presses = 0, rels = 0, shorts = 0, longs = 0, exp_presses = 0;
      logic val = 1'b0;
      int cyc = 0;
      for (int s = 0; s < 60; s++) begin
         int len = $urandom_range(1, 30);
         for (int k = 0; k < len + ((s == 59) ? 20 : 0); k++) begin
            btn_n = (s == 59) ? 1'b1 : val;
            @(negedge clk);
            checks++;
            if (obs_vec !== exp_vec) begin
               errors++;
               $display("FAIL random_model cyc %0d: got %h expected %h", cyc, obs_vec, exp_vec);
            end
            presses += int'(press_pulse);
            rels += int'(release_pulse);
            shorts += int'(short_press);
            longs += int'(long_press);
            exp_presses += int'(exp_press);
            cyc++;
         end
         val = ~val;
      end
      checks++;
      if (presses != exp_presses || rels != presses || shorts + longs != presses) begin
         errors++;
         $display("FAIL random_balance: got press=%0d rel=%0d short=%0d long=%0d expected press=%0d", presses, rels, shorts, longs, exp_presses);
      end
   endtask

   task automatic test_wrap();
      int presses = 0;
      btn_n = 1'b1;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int p = 1; p <= 256; p++) begin
         for (int i = 0; i < 16; i++) begin
            btn_n = (i < 8) ? 1'b0 : 1'b1;
            @(negedge clk);
            checks++;
            if (obs_vec !== exp_vec) begin
               errors++;
               $display("FAIL wrap_model press %0d cyc %0d: got %h expected %h", p, i, obs_vec, exp_vec);
            end
            presses += int'(press_pulse);
         end
         if (p == 255) begin
            checks++;
            if (press_count !== 8'd255) begin
               errors++;
               $display("FAIL wrap_255: got %0d expected 255", press_count);
            end
         end
      end
      checks++;
      if (press_count !== 8'd0 || presses != 256) begin
         errors++;
         $display("FAIL wrap_zero: got count=%0d pulses=%0d expected 0 256", press_count, presses);
      end
   endtask

   initial begin
      test_reset();
      test_bounce();
      test_short();
      test_long();
      test_release_bounce();
      test_mid_reset();
      test_random();
      test_wrap();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
